// File: rtl/dp_sort_regbank.sv
// Purpose : DEPTH x DATAWIDTH register bank with random write, serial shift-in and adjacent compare-and-swap for bubble sort.
// Latency : array updates and flags land one cycle after the command; reads and ooo are combinational on registered state.
// Backpress: none; one array command is accepted per cycle with priority cs_en > wr_en > sh_en, the others are dropped.
module dp_sort_regbank #(
   parameter int DATAWIDTH = 8,
   parameter int DEPTH     = 8,
   parameter int ADDRW     = 3,
   parameter bit DESCEND   = 1'b0
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 wr_en,
   input  logic [ADDRW-1:0]     wr_addr,
   input  logic [DATAWIDTH-1:0] wr_data,
   input  logic                 sh_en,
   input  logic [DATAWIDTH-1:0] sh_data,
   input  logic                 cs_en,
   input  logic                 cs_force,
   input  logic [ADDRW-1:0]     cs_addr,
   input  logic                 pass_start,
   input  logic [ADDRW-1:0]     rd_addr_a,
   output logic [DATAWIDTH-1:0] rd_data_a,
   input  logic [ADDRW-1:0]     rd_addr_b,
   output logic [DATAWIDTH-1:0] rd_data_b,
   output logic                 ooo,
   output logic                 swapped,
   output logic                 swapped_any,
   output logic                 err
);

   // One extra bit so DEPTH itself is representable when DEPTH == 2^ADDRW.
   localparam logic [ADDRW:0] LP_DEPTH   = (ADDRW+1)'(DEPTH);
   localparam logic [ADDRW:0] LP_LAST_CS = (ADDRW+1)'(DEPTH-2);

   logic [DEPTH-1:0][DATAWIDTH-1:0] r_mem;
   logic                            r_swapped;
   logic                            r_swapped_any;
   logic                            r_err;

   logic                 w_cs_legal;
   logic                 w_wr_legal;
   logic                 w_ooo;
   logic                 w_do_swap;
   logic [DATAWIDTH-1:0] w_lo;
   logic [DATAWIDTH-1:0] w_hi;

   assign w_cs_legal = ({1'b0, cs_addr} <= LP_LAST_CS);
   assign w_wr_legal = ({1'b0, wr_addr} <  LP_DEPTH);

   // Select the adjacent pair (cs_addr, cs_addr+1); an illegal index yields 0/0 so it never compares out of order.
   always_comb begin
      w_lo = '0;
      w_hi = '0;
      for (int k = 0; k < DEPTH-1; k++) begin
         if (cs_addr == ADDRW'(k)) begin
            w_lo = r_mem[k];
            w_hi = r_mem[k+1];
         end
      end
   end

   // Strict unsigned compare: equal keys are never out of order.
   assign w_ooo     = w_cs_legal && (DESCEND ? (w_lo < w_hi) : (w_lo > w_hi));
   assign w_do_swap = cs_en && w_cs_legal && (cs_force || w_ooo);

   // Two independent read ports; indices past the last entry read as zero.
   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (rd_addr_a == ADDRW'(k)) rd_data_a = r_mem[k];
         if (rd_addr_b == ADDRW'(k)) rd_data_b = r_mem[k];
      end
   end

   // Array update, single-cycle status pulses and the sticky swap flag.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_mem         <= '0;
         r_swapped     <= 1'b0;
         r_swapped_any <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_swapped <= w_do_swap;
         // Only the winning command can flag an error; dropped commands are silent.
         r_err     <= (cs_en && !w_cs_legal) || (!cs_en && wr_en && !w_wr_legal);

         // A swap in the same cycle as pass_start keeps the flag set.
         if (w_do_swap) begin
            r_swapped_any <= 1'b1;
         end else if (pass_start) begin
            r_swapped_any <= 1'b0;
         end

         if (cs_en) begin
            if (w_do_swap) begin
               for (int k = 0; k < DEPTH-1; k++) begin
                  if (cs_addr == ADDRW'(k)) begin
                     r_mem[k]   <= w_hi;
                     r_mem[k+1] <= w_lo;
                  end
               end
            end
         end else if (wr_en) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (wr_addr == ADDRW'(k)) begin
                  r_mem[k] <= wr_data;
               end
            end
         end else if (sh_en) begin
            for (int k = DEPTH-1; k > 0; k--) begin
               r_mem[k] <= r_mem[k-1];
            end
            r_mem[0] <= sh_data;
         end
      end
   end

   assign ooo         = w_ooo;
   assign swapped     = r_swapped;
   assign swapped_any = r_swapped_any;
   assign err         = r_err;

endmodule

// File: tb/tb_dp_sort_regbank.sv
// Purpose : scoreboard bench driving an ascending DEPTH=8 bank and a descending DEPTH=6 bank with identical stimulus.
// Latency : expectations are pushed as inputs are driven and popped on the falling edge of the same cycle.
// Backpress: none; the monitor pops one expectation per cycle whenever the queue is non-empty.
module tb_dp_sort_regbank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr_n, wr_en, sh_en, cs_en, cs_force, pass_start;
   logic [2:0] wr_addr, cs_addr, rd_addr_a, rd_addr_b;
   logic [7:0] wr_data, sh_data;

   logic [1:0][7:0] d_rda, d_rdb;
   logic [1:0]      d_ooo, d_sw, d_any, d_err;

   dp_sort_regbank #(.DATAWIDTH(8), .DEPTH(8), .ADDRW(3), .DESCEND(1'b0)) u_asc (
      .clk(clk), .clr_n(clr_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .sh_en(sh_en), .sh_data(sh_data), .cs_en(cs_en), .cs_force(cs_force), .cs_addr(cs_addr),
      .pass_start(pass_start), .rd_addr_a(rd_addr_a), .rd_data_a(d_rda[0]),
      .rd_addr_b(rd_addr_b), .rd_data_b(d_rdb[0]), .ooo(d_ooo[0]), .swapped(d_sw[0]),
      .swapped_any(d_any[0]), .err(d_err[0]));

   dp_sort_regbank #(.DATAWIDTH(8), .DEPTH(6), .ADDRW(3), .DESCEND(1'b1)) u_dsc (
      .clk(clk), .clr_n(clr_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .sh_en(sh_en), .sh_data(sh_data), .cs_en(cs_en), .cs_force(cs_force), .cs_addr(cs_addr),
      .pass_start(pass_start), .rd_addr_a(rd_addr_a), .rd_data_a(d_rda[1]),
      .rd_addr_b(rd_addr_b), .rd_data_b(d_rdb[1]), .ooo(d_ooo[1]), .swapped(d_sw[1]),
      .swapped_any(d_any[1]), .err(d_err[1]));

   // ---------------- reference model: plain arrays following the command rules ----------------
   int m_depth [2] = '{8, 6};
   bit m_desc  [2] = '{1'b0, 1'b1};
   int m_mem   [2][8];
   bit m_sw    [2];
   bit m_any   [2];
   bit m_err   [2];

   function automatic int m_rd(int n, int a);
      return (a < m_depth[n]) ? m_mem[n][a] : 0;
   endfunction

   function automatic bit m_ooo(int n, int a);
      if (a > m_depth[n] - 2) return 1'b0;
      if (m_desc[n]) return m_mem[n][a] < m_mem[n][a+1];
      return m_mem[n][a] > m_mem[n][a+1];
   endfunction

   task automatic m_clock(int n);
      int a  = int'(cs_addr);
      int wa = int'(wr_addr);
      int d  = m_depth[n];
      int t;
      bit sw = 1'b0;
      bit er = 1'b0;
      if (!clr_n) begin
         for (int k = 0; k < 8; k++) m_mem[n][k] = 0;
         m_sw[n] = 1'b0; m_any[n] = 1'b0; m_err[n] = 1'b0;
         return;
      end
      if (cs_en) begin
         if (a <= d - 2) begin
            if (cs_force || m_ooo(n, a)) begin
               t = m_mem[n][a]; m_mem[n][a] = m_mem[n][a+1]; m_mem[n][a+1] = t;
               sw = 1'b1;
            end
         end else er = 1'b1;
      end else if (wr_en) begin
         if (wa < d) m_mem[n][wa] = int'(wr_data);
         else er = 1'b1;
      end else if (sh_en) begin
         for (int k = d - 1; k > 0; k--) m_mem[n][k] = m_mem[n][k-1];
         m_mem[n][0] = int'(sh_data);
      end
      m_any[n] = sw ? 1'b1 : (pass_start ? 1'b0 : m_any[n]);
      m_sw[n]  = sw;
      m_err[n] = er;
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [1:0][7:0] rda;
      logic [1:0][7:0] rdb;
      logic [1:0]      ooo;
      logic [1:0]      sw;
      logic [1:0]      any;
      logic [1:0]      er;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;
   bit   sort_chk = 1'b0;
   int   fix_a = -1;
   int   fix_b = -1;
   int   sa[$];
   int   sb[$];

   task automatic chk(string nm, int n, logic [7:0] got, logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, n, $time, got, exp);
      end
   endtask

   // Monitor: every cycle the DUT outputs are valid, so pop one expectation per falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            for (int n = 0; n < 2; n++) begin
               chk("rd_data_a",   n, d_rda[n],        e.rda[n]);
               chk("rd_data_b",   n, d_rdb[n],        e.rdb[n]);
               chk("ooo",         n, 8'(d_ooo[n]),    8'(e.ooo[n]));
               chk("swapped",     n, 8'(d_sw[n]),     8'(e.sw[n]));
               chk("swapped_any", n, 8'(d_any[n]),    8'(e.any[n]));
               chk("err",         n, 8'(d_err[n]),    8'(e.er[n]));
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step(bit cl, bit we, bit [2:0] wa, bit [7:0] wd, bit se, bit [7:0] sd,
                       bit ce, bit cf, bit [2:0] ca, bit ps);
      exp_t e;
      clr_n = cl; wr_en = we; wr_addr = wa; wr_data = wd; sh_en = se; sh_data = sd;
      cs_en = ce; cs_force = cf; cs_addr = ca; pass_start = ps;
      rd_addr_a = (fix_a >= 0) ? 3'(fix_a) : 3'($urandom_range(0, 7));
      rd_addr_b = (fix_b >= 0) ? 3'(fix_b) : 3'($urandom_range(0, 7));
      if (chk_en) begin
         for (int n = 0; n < 2; n++) begin
            e.rda[n] = 8'(m_rd(n, int'(rd_addr_a)));
            e.rdb[n] = 8'(m_rd(n, int'(rd_addr_b)));
            e.ooo[n] = m_ooo(n, int'(cs_addr));
            e.sw[n]  = m_sw[n];
            e.any[n] = m_any[n];
            e.er[n]  = m_err[n];
         end
         q.push_back(e);
      end
      #2;
      if (sort_chk) begin
         chk("sorted_asc", 0, d_rda[0], 8'(sa[rd_addr_a]));
         chk("sorted_dsc", 1, d_rdb[1], (rd_addr_b < 3'd6) ? 8'(sb[rd_addr_b]) : 8'h00);
      end
      @(posedge clk);
      m_clock(0);
      m_clock(1);
      #1;
   endtask

   task automatic idle();                              step(1,0,0,0,0,0,0,0,0,0); endtask
   task automatic rst();                               step(0,0,0,0,0,0,0,0,0,0); endtask
   task automatic wr(bit [2:0] a, bit [7:0] d);        step(1,1,a,d,0,0,0,0,0,0); endtask
   task automatic sh(bit [7:0] d);                     step(1,0,0,0,1,d,0,0,0,0); endtask
   task automatic cs(bit [2:0] a, bit f, bit ps);      step(1,0,0,0,0,0,1,f,a,ps); endtask

   task automatic readback();
      for (int k = 0; k < 8; k++) begin
         fix_a = k; fix_b = 7 - k;
         idle();
      end
      fix_a = -1; fix_b = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit done;
      int v;
      @(posedge clk); #1;
      rst();                       // DUT state unknown before this edge; nothing to compare yet
      chk_en = 1'b1;
      idle();

      // Reset clears a fully written bank.
      for (int k = 0; k < 8; k++) wr(3'(k), 8'((k + 1) * 8'h11));
      readback();
      rst();
      readback();

      // Conditional swap, then repeat is a no-op.
      wr(3'd2, 8'h40); wr(3'd3, 8'h10);
      cs(3'd2, 1'b0, 1'b0);
      cs(3'd2, 1'b0, 1'b0);
      readback();

      // Equal keys do not swap; forced swap exchanges in-order keys.
      wr(3'd0, 8'h55); wr(3'd1, 8'h55);
      cs(3'd0, 1'b0, 1'b0);
      wr(3'd0, 8'h01); wr(3'd1, 8'h02);
      cs(3'd0, 1'b1, 1'b0);
      idle();

      // Boundaries: illegal cs_addr, write index past DEPTH on the 6-deep bank, reads past DEPTH.
      cs(3'd7, 1'b1, 1'b0);
      cs(3'd6, 1'b0, 1'b0);
      cs(3'd5, 1'b1, 1'b0);
      wr(3'd6, 8'hA6);
      wr(3'd7, 8'hA7);
      idle();
      readback();

      // Priority and sticky flag.
      wr(3'd4, 8'h90); wr(3'd5, 8'h20);
      step(1, 1, 3'd0, 8'hEE, 1, 8'h77, 1, 0, 3'd4, 1);
      step(1, 0, 3'd0, 8'h00, 0, 8'h00, 0, 0, 3'd0, 1);
      idle();
      readback();

      // Randomized mixed traffic including occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
              $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
              $urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)),
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
              $urandom_range(0, 4) == 0);
      end

      // Full sort: shift in random keys, run passes until neither bank swaps.
      for (int k = 0; k < 8; k++) begin
         v = int'($urandom_range(0, 255));
         sa.push_back(v);
         if (k >= 2) sb.push_back(v);
         sh(8'(v));
      end
      done = 1'b0;
      for (int p = 0; p < 20 && !done; p++) begin
         for (int i = 0; i < 7; i++) cs(3'(i), 1'b0, i == 0);
         if (!m_any[0] && !m_any[1]) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL sort_converge: got not-converged expected converged within 20 passes");
      end
      sa.sort();
      sb.rsort();
      sort_chk = 1'b1;
      for (int k = 0; k < 8; k++) begin
         fix_a = k; fix_b = k;
         idle();
      end
      sort_chk = 1'b0;
      fix_a = -1; fix_b = -1;

      // Drain the scoreboard.
      repeat (3) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dp_sort_regbank.md
Name: dp_sort_regbank

Overview:
- Parametrised successor to the single load/clear datapath register.
- Holds DEPTH entries of DATAWIDTH bits, loadable by random write or serial shift-in.
- Provides a one-cycle compare-and-swap of adjacent entries; this is the core step of the bubble-sort datapath.
- A sticky "swap occurred" flag lets the sort controller detect a pass with no exchanges, which marks the end of the sort.

Parameters:
- DATAWIDTH, 8, bits per entry.
- DEPTH, 8, number of entries (>= 2).
- ADDRW, 3, address width; must satisfy 2^ADDRW >= DEPTH.
- DESCEND, 0, sort order. 0 = ascending: swap when entry[i] > entry[i+1]. 1 = descending: swap when entry[i] < entry[i+1].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr_n  in  1  synchronous active-low reset.
- wr_en  in  1  random write strobe.
- wr_addr  in  ADDRW  write index.
- wr_data  in  DATAWIDTH  write data.
- sh_en  in  1  shift-in strobe.
- sh_data  in  DATAWIDTH  data entering entry 0.
- cs_en  in  1  compare-and-swap strobe.
- cs_force  in  1  when 1, swap unconditionally; when 0, swap only if out of order.
- cs_addr  in  ADDRW  lower index i of the pair (i, i+1).
- pass_start  in  1  clears the sticky swap flag.
- rd_addr_a  in  ADDRW  read port A index.
- rd_data_a  out  DATAWIDTH  entry[rd_addr_a], combinational read of registered state.
- rd_addr_b  in  ADDRW  read port B index.
- rd_data_b  out  DATAWIDTH  entry[rd_addr_b], combinational read.
- ooo  out  1  combinational: pair at cs_addr is out of order per DESCEND.
- swapped  out  1  registered: 1 for one cycle after an executed swap.
- swapped_any  out  1  registered sticky flag.
- err  out  1  registered one-cycle pulse for an illegal command.

Behaviour:

Reset:
- When clr_n == 0 at a clk edge: all entries, swapped, swapped_any and err become 0.
- Reset overrides every other input.
- Reset asserted mid-sort discards all contents; no partial swap survives.

Command priority (at most one array update per cycle): cs_en > wr_en > sh_en. Lower-priority commands in the same cycle are ignored; they do not raise err.

Compare-and-swap (cs_en = 1):
- Legal only for cs_addr <= DEPTH-2.
- The swap executes when cs_force == 1 or ooo == 1. Then entry[i] gets the old entry[i+1] and entry[i+1] gets the old entry[i] at the same edge.
- Latency: one cycle. New values are visible on the read ports in the following cycle.
- swapped is set to 1 for that cycle only, and swapped_any is set.
- No swap (in order and cs_force == 0): the array is unchanged and swapped = 0.
- cs_addr >= DEPTH-1: no array change, err = 1 next cycle, swapped = 0.

ooo comparison:
- Unsigned comparison.
- Equal values are never out of order, so equal keys never swap unless forced.
- If cs_addr >= DEPTH-1, ooo = 0.

Write (wr_en = 1, no cs_en):
- wr_addr < DEPTH: entry[wr_addr] <= wr_data.
- wr_addr >= DEPTH: ignored, err = 1 next cycle.

Shift (sh_en = 1, neither cs_en nor wr_en):
- entry[k] <= entry[k-1] for k = DEPTH-1 down to 1, and entry[0] <= sh_data.
- The old entry[DEPTH-1] is discarded.

swapped_any:
- Set by any executed swap.
- Cleared by pass_start.
- If pass_start and an executed swap occur in the same cycle, set wins (result 1).

Read ports:
- rd_addr >= DEPTH returns 0.
- Port A and port B may address the same entry.

err and swapped:
- Both deassert after one cycle unless retriggered.
- err covers illegal cs_addr and illegal wr_addr only.

Test Plan:
- Reset and readback: write 0x11..0x88 to entries 0..7, assert clr_n = 0 for one cycle. All entries read 0; swapped, swapped_any and err are all 0.
- Conditional swap, ascending (DESCEND = 0): entry[2] = 0x40, entry[3] = 0x10, cs_en with cs_addr = 2. ooo = 1 before the edge. Next cycle entry[2] = 0x10, entry[3] = 0x40, swapped = 1, swapped_any = 1. Repeating the same command gives no change and swapped = 0.
- Equal and forced: entry[0] = entry[1] = 0x55 gives ooo = 0 and no swap. With entry[0] = 0x01, entry[1] = 0x02 and cs_force = 1, the values exchange and swapped = 1.
- Boundaries: cs_addr = 7 (DEPTH = 8) leaves the array unchanged and pulses err for one cycle. wr_addr out of range (only when DEPTH < 2^ADDRW, e.g. DEPTH = 6, wr_addr = 6) is ignored and pulses err. rd_addr >= DEPTH reads 0.
- Priority and sticky flag: cs_en, wr_en and sh_en in the same cycle → only the swap occurs. pass_start together with an executed swap → swapped_any stays 1. pass_start alone on the next cycle → swapped_any = 0.
- Full sort: shift in 0x05, 0x03, 0x08, 0x01 (DEPTH = 4), then run adjacent cs passes with pass_start each pass until a pass leaves swapped_any = 0. Final entries 0..3 are 0x01, 0x03, 0x05, 0x08. With DESCEND = 1 the final order is 0x08, 0x05, 0x03, 0x01.
